// File: rtl/iob_status_rd_pkg.sv
// Shared configuration for the IOb status read responder: default geometry,
// FSM state codes and the address index of the flag word.
package iob_status_rd_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_N_WORDS = 4;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_RD_LAT  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RESP = 2'd2
    } state_e;

    // The flag word sits directly after the last snapshot word.
    function automatic int flag_idx(input int n_words);
        return n_words;
    endfunction

endpackage

// File: rtl/iob_status_rd_reg_e.sv
// Enabled register with asynchronous active-high reset and clock enable;
// used for each snapshot word and for the read-data output.
module iob_reg_e #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_q <= RST_VAL;
        end else if (cke_i && en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/iob_status_rd.sv
// IOb read-side responder for a bank of captured status words with sticky
// new-data flags. Optional macro IOB_STATUS_RD_CLR_ON_READ_EN: reads also clear flags.
module iob_status_rd
    import iob_status_rd_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int N_WORDS = DEF_N_WORDS,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int RD_LAT  = DEF_RD_LAT
) (
    input  logic                      clk_i,
    input  logic                      cke_i,
    input  logic                      arst_i,
    input  logic                      iob_valid_i,
    input  logic [ADDR_W-1:0]         iob_addr_i,
    input  logic [DATA_W/8-1:0]       iob_wstrb_i,
    output logic                      iob_ready_o,
    output logic                      iob_rvalid_o,
    output logic [DATA_W-1:0]         iob_rdata_o,
    input  logic [N_WORDS*DATA_W-1:0] status_i,
    input  logic [N_WORDS-1:0]        status_upd_i,
    output logic [N_WORDS-1:0]        new_o
);

    localparam int IDX_W    = ADDR_W - 2;
    localparam int FLAG_IDX = flag_idx(N_WORDS);

    state_e                          state_q;
    logic                            rvalid_q;
    logic [N_WORDS-1:0]              new_q, new_d;
    logic [N_WORDS-1:0]              clr;
    logic [N_WORDS-1:0]              idx_oh;
    logic [N_WORDS-1:0][DATA_W-1:0]  snap;
    logic [DATA_W-1:0]               rdata_d;
    logic [IDX_W-1:0]                idx;
    logic                            is_wr, rd_acc, wr_acc;
    logic                            unused_addr;

    assign idx         = iob_addr_i[ADDR_W-1:2];
    assign unused_addr = ^iob_addr_i[1:0];
    assign is_wr       = |iob_wstrb_i;
    assign iob_ready_o = iob_valid_i & cke_i & (state_q == IDLE);
    assign rd_acc      = iob_ready_o & ~is_wr;
    assign wr_acc      = iob_ready_o & is_wr;

    genvar k;
    generate
        for (k = 0; k < N_WORDS; k++) begin : g_snap
            iob_reg_e #(.DATA_W(DATA_W)) u_snap (
                .clk_i  (clk_i),
                .arst_i (arst_i),
                .cke_i  (cke_i),
                .en_i   (status_upd_i[k]),
                .data_i (status_i[k*DATA_W +: DATA_W]),
                .data_o (snap[k])
            );
        end
    endgenerate

    always_comb begin
        idx_oh = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            idx_oh[i] = (idx == IDX_W'(i));
        end
    end

    // Snapshot registers update on the same edge, so this mux sees pre-update values.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (idx_oh[i]) rdata_d = snap[i];
        end
        if (idx == IDX_W'(FLAG_IDX)) rdata_d[N_WORDS-1:0] = new_q;
    end

    iob_reg_e #(.DATA_W(DATA_W)) u_rdata (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .en_i   (rd_acc),
        .data_i (rdata_d),
        .data_o (iob_rdata_o)
    );

    always_comb begin
        clr = '0;
        if (wr_acc) clr = idx_oh;
`ifdef IOB_STATUS_RD_CLR_ON_READ_EN
        if (rd_acc) clr = idx_oh;
`endif
        // Capture pulses are applied last so a coincident set wins over a clear.
        new_d = (new_q & ~clr) | status_upd_i;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            new_q <= '0;
        end else if (cke_i) begin
            new_q <= new_d;
        end
    end

    assign new_o = new_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
        end else if (cke_i) begin
            case (state_q)
                IDLE: begin
                    rvalid_q <= 1'b0;
                    if (rd_acc) begin
                        if (RD_LAT == 2) begin
                            state_q <= PEND;
                        end else begin
                            state_q  <= RESP;
                            rvalid_q <= 1'b1;
                        end
                    end
                end
                PEND: begin
                    state_q  <= RESP;
                    rvalid_q <= 1'b1;
                end
                RESP: begin
                    state_q  <= IDLE;
                    rvalid_q <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign iob_rvalid_o = rvalid_q;

endmodule

// File: tb/tb_iob_status_rd.sv
// Directed bench for iob_status_rd: one RD_LAT=1 instance and one RD_LAT=2 instance
// sharing stimulus (separate valid lines); expectations follow the build macro.
module tb_iob_status_rd;

`ifdef IOB_STATUS_RD_CLR_ON_READ_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         cke, arst, v1, v2;
    logic [7:0]   addr;
    logic [3:0]   wstrb;
    logic [127:0] status;
    logic [3:0]   upd;
    logic         r1, rv1, r2, rv2;
    logic [31:0]  rd1, rd2;
    logic [3:0]   new1, new2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iob_status_rd #(.DATA_W(32), .N_WORDS(4), .ADDR_W(8), .RD_LAT(1)) dut1 (
        .clk_i(clk), .cke_i(cke), .arst_i(arst), .iob_valid_i(v1), .iob_addr_i(addr),
        .iob_wstrb_i(wstrb), .iob_ready_o(r1), .iob_rvalid_o(rv1), .iob_rdata_o(rd1),
        .status_i(status), .status_upd_i(upd), .new_o(new1)
    );

    iob_status_rd #(.DATA_W(32), .N_WORDS(4), .ADDR_W(8), .RD_LAT(2)) dut2 (
        .clk_i(clk), .cke_i(cke), .arst_i(arst), .iob_valid_i(v2), .iob_addr_i(addr),
        .iob_wstrb_i(wstrb), .iob_ready_o(r2), .iob_rvalid_o(rv2), .iob_rdata_o(rd2),
        .status_i(status), .status_upd_i(upd), .new_o(new2)
    );

    // One read transaction; returns acceptance, observed latency, data and
    // whether rvalid dropped again the cycle after it was seen.
    task automatic bus_read(input bit sel, input int idx, input logic [3:0] m,
                            output logic rdy, output int lat, output logic [31:0] data,
                            output logic dropped);
        @(negedge clk);
        addr = 8'(idx << 2); wstrb = 4'h0; upd = m;
        if (sel) v2 = 1'b1; else v1 = 1'b1;
        #1 rdy = sel ? r2 : r1;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0; v2 = 1'b0; upd = 4'h0;
        lat = 0; data = 'x; dropped = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (sel ? rv2 : rv1) begin
                lat = c; data = sel ? rd2 : rd1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        dropped = !(sel ? rv2 : rv1);
    endtask

    task automatic bus_write(input int idx, input logic [3:0] m, output logic rdy);
        @(negedge clk);
        addr = 8'(idx << 2); wstrb = 4'hF; upd = m; v1 = 1'b1;
        #1 rdy = r1;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0; wstrb = 4'h0; upd = 4'h0;
    endtask

    task automatic pulse_upd(input logic [3:0] m);
        @(negedge clk);
        upd = m;
        @(negedge clk);
        upd = 4'h0;
    endtask

    task automatic test_reset;
        logic rdy, dr; int lat; logic [31:0] d;
        total++; if (new1 !== 4'h0 || rv1 !== 1'b0 || rd1 !== 32'h0 || rv2 !== 1'b0 || rd2 !== 32'h0) begin
            bad++; $display("FAIL reset_state new=%h rv=%b rd=%h rv2=%b rd2=%h exp 0", new1, rv1, rd1, rv2, rd2);
        end
        @(negedge clk); arst = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            bus_read(1'b0, i, 4'h0, rdy, lat, d, dr);
            total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rd_ready idx=%0d got=%b exp=1", i, rdy); end
            total++; if (lat !== 1) begin bad++; $display("FAIL reset_rd_lat idx=%0d got=%0d exp=1", i, lat); end
            total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_rd_data idx=%0d got=%h exp=0", i, d); end
            total++; if (dr !== 1'b1) begin bad++; $display("FAIL reset_rd_pulse idx=%0d rvalid not one cycle", i); end
        end
        bus_read(1'b1, 0, 4'h0, rdy, lat, d, dr);
        total++; if (lat !== 2) begin bad++; $display("FAIL lat2 got=%0d exp=2", lat); end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL lat2_data got=%h exp=0", d); end
        total++; if (dr !== 1'b1) begin bad++; $display("FAIL lat2_pulse rvalid not one cycle"); end
    endtask

    task automatic test_capture;
        logic rdy, dr; int lat; logic [31:0] d;
        status[2*32 +: 32] = 32'hDEADBEEF;
        pulse_upd(4'b0100);
        total++; if (new1 !== 4'b0100) begin bad++; $display("FAIL cap_flag got=%b exp=0100", new1); end
        bus_read(1'b0, 2, 4'h0, rdy, lat, d, dr);
        total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL cap_data got=%h exp=deadbeef", d); end
        total++; if (new1 !== (CLR ? 4'b0000 : 4'b0100)) begin bad++; $display("FAIL cap_flag_after_rd got=%b", new1); end
    endtask

    task automatic test_flags;
        logic rdy, dr; int lat; logic [31:0] d;
        status[0 +: 32] = 32'h11111111;
        pulse_upd(4'b0101);
        bus_read(1'b0, 4, 4'h0, rdy, lat, d, dr);
        total++; if (d !== 32'h5) begin bad++; $display("FAIL flag_word got=%h exp=5", d); end
        bus_write(0, 4'h0, rdy);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b exp=1", rdy); end
        total++; if (new1 !== 4'b0100) begin bad++; $display("FAIL wr_clear got=%b exp=0100", new1); end
        total++; if (rv1 !== 1'b0) begin bad++; $display("FAIL wr_no_rvalid got=%b exp=0", rv1); end
        bus_write(5, 4'h0, rdy);
        total++; if (new1 !== 4'b0100) begin bad++; $display("FAIL wr_oob got=%b exp=0100", new1); end
        bus_read(1'b0, 5, 4'h0, rdy, lat, d, dr);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rd_oob got=%h exp=0", d); end
        bus_read(1'b0, 0, 4'h0, rdy, lat, d, dr);
        total++; if (d !== 32'h11111111) begin bad++; $display("FAIL rd_idx0 got=%h exp=11111111", d); end
    endtask

    task automatic test_same_cycle_upd;
        logic rdy, dr; int lat; logic [31:0] d;
        status[1*32 +: 32] = 32'hA5A5A5A5;
        pulse_upd(4'b0010);
        status[1*32 +: 32] = 32'h12345678;
        bus_read(1'b0, 1, 4'b0010, rdy, lat, d, dr);
        total++; if (d !== 32'hA5A5A5A5) begin bad++; $display("FAIL upd_rd_old got=%h exp=a5a5a5a5", d); end
        total++; if (new1 !== 4'b0110) begin bad++; $display("FAIL upd_rd_set_wins got=%b exp=0110", new1); end
        bus_read(1'b0, 1, 4'h0, rdy, lat, d, dr);
        total++; if (d !== 32'h12345678) begin bad++; $display("FAIL upd_rd_new got=%h exp=12345678", d); end
        total++; if (new1 !== (CLR ? 4'b0100 : 4'b0110)) begin bad++; $display("FAIL upd_rd_flag got=%b", new1); end
    endtask

    task automatic test_set_wins;
        logic rdy, dr; int lat; logic [31:0] d;
        status[3*32 +: 32] = 32'hCAFE0003;
        bus_write(3, 4'b1000, rdy);
        total++; if (new1[3] !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", new1[3]); end
        bus_read(1'b0, 3, 4'h0, rdy, lat, d, dr);
        total++; if (d !== 32'hCAFE0003) begin bad++; $display("FAIL set_wins_data got=%h exp=cafe0003", d); end
        total++; if (new1[3] !== (CLR ? 1'b0 : 1'b1)) begin bad++; $display("FAIL clr_on_read got=%b exp=%b", new1[3], !CLR); end
    endtask

    task automatic test_cke;
        logic rdy, dr; int lat; logic [31:0] d;
        @(negedge clk);
        cke = 1'b0; status[0 +: 32] = 32'h77; upd = 4'b0001; addr = 8'h0; wstrb = 4'h0; v1 = 1'b1;
        #1;
        total++; if (r1 !== 1'b0) begin bad++; $display("FAIL cke_ready got=%b exp=0", r1); end
        @(negedge clk);
        total++; if (new1[0] !== 1'b0 || rv1 !== 1'b0) begin bad++; $display("FAIL cke_hold new0=%b rv=%b exp 0 0", new1[0], rv1); end
        cke = 1'b1; upd = 4'h0; v1 = 1'b0;
        bus_read(1'b0, 0, 4'h0, rdy, lat, d, dr);
        total++; if (d !== 32'h11111111) begin bad++; $display("FAIL cke_no_capture got=%h exp=11111111", d); end
    endtask

    task automatic test_back_to_back;
        logic seen;
        @(negedge clk);
        addr = 8'h0; wstrb = 4'h0; v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        arst = 1'b1;
        #1;
        total++; if (rv2 !== 1'b0 || new1 !== 4'h0) begin bad++; $display("FAIL rst_mid rv2=%b new=%b exp 0 0", rv2, new1); end
        @(negedge clk);
        arst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rv2) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_rvalid got=%b exp=0", seen); end
        @(negedge clk);
        addr = 8'h4; v2 = 1'b1;
        #1;
        total++; if (r2 !== 1'b1) begin bad++; $display("FAIL b2b_first_ready got=%b exp=1", r2); end
        @(negedge clk);
        total++; if (r2 !== 1'b0 || rv2 !== 1'b0) begin bad++; $display("FAIL b2b_pend ready=%b rv=%b exp 0 0", r2, rv2); end
        @(negedge clk);
        total++; if (r2 !== 1'b0 || rv2 !== 1'b1) begin bad++; $display("FAIL b2b_resp ready=%b rv=%b exp 0 1", r2, rv2); end
        total++; if (rd2 !== 32'h0) begin bad++; $display("FAIL b2b_data got=%h exp=0", rd2); end
        @(negedge clk);
        total++; if (r2 !== 1'b1 || rv2 !== 1'b0) begin bad++; $display("FAIL b2b_idle ready=%b rv=%b exp 1 0", r2, rv2); end
        @(negedge clk);
        v2 = 1'b0;
    endtask

    initial begin
        cke = 1'b1; arst = 1'b1; v1 = 1'b0; v2 = 1'b0;
        addr = 8'h0; wstrb = 4'h0; status = '0; upd = 4'h0;
        #12;
        test_reset;
        test_capture;
        test_flags;
        test_same_cycle_upd;
        test_set_wins;
        test_cke;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
